// File: rtl/float12_to_fixed_if.sv
// Handshake bundle for the float12 -> fixed-point decoder.
// Upstream words enter on *_i and results leave on *_o, both with valid/ready.
interface float12_to_fixed_if #(
    parameter int OUT_W = 16
);
    logic             valid_i;
    logic             ready_o;
    logic [11:0]      data_i;
    logic             relu_en_i;
    logic             valid_o;
    logic             ready_i;
    logic [OUT_W-1:0] data_o;
    logic             sat_o;

    modport master (
        output valid_i, data_i, relu_en_i, ready_i,
        input  ready_o, valid_o, data_o, sat_o
    );

    modport slave (
        input  valid_i, data_i, relu_en_i, ready_i,
        output ready_o, valid_o, data_o, sat_o
    );
endinterface

// File: rtl/float12_to_fixed.sv
// Three-stage float12 (s|e5 bias 15|m6) to signed fixed-point converter.
// Stages: unpack, align, round/saturate/sign; one shared enable gives full backpressure.
module float12_to_fixed #(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    float12_to_fixed_if.slave   bus
);
    localparam int MAG_W = OUT_W + 8;
    localparam int SUM_W = OUT_W + 9;
    localparam logic signed [7:0] K_OFS = 8'(FRAC_W - 21);
    localparam logic signed [7:0] K_SAT = 8'(OUT_W);
    localparam logic [SUM_W-1:0]  NEG_LIM = {{(SUM_W-1){1'b0}}, 1'b1} << (OUT_W - 1);
    localparam logic [SUM_W-1:0]  POS_LIM = NEG_LIM - 1'b1;
    localparam logic [OUT_W-1:0]  MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    logic w_en;

    logic              r_s1_v, r_s1_s, r_s1_zero, r_s1_relu;
    logic [5:0]        r_s1_m;
    logic signed [7:0] r_s1_k;

    logic              r_s2_v, r_s2_s, r_s2_relu, r_s2_rnd;
    logic [MAG_W-1:0]  r_s2_mag;

    logic              r_valid_o, r_sat_o;
    logic [OUT_W-1:0]  r_data_o;

    logic [6:0]        w_sig;
    logic [7:0]        w_nk;
    logic [7:0]        w_shr;
    logic [MAG_W-1:0]  w_mag;
    logic              w_rnd;
    logic [SUM_W-1:0]  w_magp;
    logic [OUT_W-1:0]  w_res;
    logic              w_sat;

    assign w_en        = bus.ready_i | ~r_valid_o;
    assign bus.ready_o = w_en;
    assign bus.valid_o = r_valid_o;
    assign bus.data_o  = r_data_o;
    assign bus.sat_o   = r_sat_o;

    assign w_sig = {1'b1, r_s1_m};
    assign w_nk  = 8'(-r_s1_k);

    // Left shifts at or beyond OUT_W always exceed full scale, so they clamp to all-ones
    always_comb begin
        w_mag = '0;
        w_rnd = 1'b0;
        w_shr = '0;
        if (!r_s1_zero) begin
            if (!r_s1_k[7]) begin
                if (r_s1_k >= K_SAT) w_mag = '1;
                else                 w_mag = MAG_W'(w_sig) << r_s1_k[5:0];
            end else begin
                w_shr = {w_sig, 1'b0} >> w_nk;
                w_mag = MAG_W'(w_shr[7:1]);
                w_rnd = w_shr[0];
            end
        end
    end

    assign w_magp = SUM_W'(r_s2_mag) + SUM_W'(r_s2_rnd);

    always_comb begin
        w_res = '0;
        w_sat = 1'b0;
        if (r_s2_s && r_s2_relu) begin
            w_res = '0;
        end else if (!r_s2_s) begin
            if (w_magp > POS_LIM) begin
                w_res = MAX_POS;
                w_sat = 1'b1;
            end else begin
                w_res = w_magp[OUT_W-1:0];
            end
        end else begin
            if (w_magp > NEG_LIM) begin
                w_res = MIN_NEG;
                w_sat = 1'b1;
            end else begin
                w_res = -w_magp[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_v    <= 1'b0;
            r_s1_s    <= 1'b0;
            r_s1_zero <= 1'b1;
            r_s1_relu <= 1'b0;
            r_s1_m    <= '0;
            r_s1_k    <= '0;
            r_s2_v    <= 1'b0;
            r_s2_s    <= 1'b0;
            r_s2_relu <= 1'b0;
            r_s2_rnd  <= 1'b0;
            r_s2_mag  <= '0;
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
            r_sat_o   <= 1'b0;
        end else if (w_en) begin
            r_s1_v    <= bus.valid_i;
            r_s1_s    <= bus.data_i[11];
            r_s1_zero <= (bus.data_i[10:6] == 5'd0);
            r_s1_relu <= bus.relu_en_i;
            r_s1_m    <= bus.data_i[5:0];
            r_s1_k    <= $signed({3'b000, bus.data_i[10:6]}) + K_OFS;
            r_s2_v    <= r_s1_v;
            r_s2_s    <= r_s1_s;
            r_s2_relu <= r_s1_relu;
            r_s2_rnd  <= w_rnd;
            r_s2_mag  <= w_mag;
            r_valid_o <= r_s2_v;
            r_data_o  <= w_res;
            r_sat_o   <= w_sat;
        end
    end
endmodule

// File: tb/tb_float12_to_fixed.sv
// Directed-vector bench for float12_to_fixed (OUT_W=16, FRAC_W=8) with an in-order scoreboard.
module tb_float12_to_fixed;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    float12_to_fixed_if #(.OUT_W(16)) bus();

    float12_to_fixed #(.OUT_W(16), .FRAC_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];
    bit rand_rdy = 1'b0;

    localparam int NV = 20;
    logic [11:0] vd[NV] = '{12'h3C0, 12'hC10, 12'h000, 12'h03F, 12'h800, 12'h040, 12'h180,
                            12'h980, 12'h140, 12'h7C0, 12'hFC0, 12'hD80, 12'h580, 12'hC10,
                            12'hFC0, 12'h3C0, 12'h57F, 12'h301, 12'hB01, 12'h700};
    logic        vr[NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    logic [15:0] ed[NV] = '{16'h0100, 16'hFD80, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
                            16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000,
                            16'h0000, 16'h0100, 16'h7F00, 16'h0021, 16'hFFDF, 16'h7FFF};
    logic        es[NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send(input int idx);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        bus.valid_i   = 1'b1;
        bus.data_i    = vd[idx];
        bus.relu_en_i = vr[idx];
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = bus.ready_o;
            @(posedge clk);
            #1;
            tries++;
        end
        if (acc) exp_q.push_back({es[idx], ed[idx]});
        else     chk("send_timeout", 32'(tries), 32'd0);
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) bus.ready_i = 1'($urandom_range(0, 1));
        else          bus.ready_i = 1'b1;
    end

    logic        hold = 1'b0;
    logic [16:0] held;
    logic [16:0] e_w;

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            chk("ready_o", 32'(bus.ready_o), 32'(!(bus.valid_o && !bus.ready_i)));
            if (hold) chk("stall_hold", 32'({bus.sat_o, bus.data_o}), 32'(held));
            hold = 1'b0;
            if (bus.valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'({bus.sat_o, bus.data_o}), 32'h1_DEAD);
                end else if (bus.ready_i) begin
                    e_w = exp_q.pop_front();
                    chk("sat_data", 32'({bus.sat_o, bus.data_o}), 32'(e_w));
                end else begin
                    hold = 1'b1;
                    held = {bus.sat_o, bus.data_o};
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int t;
        bus.valid_i   = 1'b0;
        bus.data_i    = '0;
        bus.relu_en_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
        chk("rst_data_o",  32'(bus.data_o),  32'd0);
        chk("rst_sat_o",   32'(bus.sat_o),   32'd0);
        @(posedge clk);
        #1;

        // single word latency
        bus.valid_i   = 1'b1;
        bus.data_i    = 12'h3C0;
        bus.relu_en_i = 1'b0;
        exp_q.push_back({1'b0, 16'h0100});
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        cyc = 1;
        while (!bus.valid_o && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd3);
        idle(3);

        // all directed vectors back to back at full rate
        for (int i = 0; i < NV; i++) send(i);
        idle(6);
        chk("drain_direct", 32'(exp_q.size()), 32'd0);

        // random backpressure with a reset in the middle of the stream
        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send((i * 3) % NV);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                bus.valid_i = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                exp_q.delete();
                @(negedge clk);
                chk("post_rst_valid", 32'(bus.valid_o), 32'd0);
                @(posedge clk);
                #1;
                idle(8);
            end
            send((i * 7 + 1) % NV);
        end
        bus.valid_i = 1'b0;
        rand_rdy = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_bp", 32'(exp_q.size()), 32'd0);
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/float12_to_fixed.md
Name: float12_to_fixed

Overview:
- Pipelined decoder from the team's 12-bit float format to signed two's-complement fixed point.
- Float format: sign[11], exp[10:6] with bias 15, man[5:0] with hidden 1.
- Sits downstream of the float12 adder/accumulator chain and feeds fixed-point consumers (activation LUTs, output writeback).
- Valid/ready handshake with full backpressure, 3-cycle latency.

Parameters:
- OUT_W, 16, output width in bits; legal range 10..32.
- FRAC_W, 8, number of fractional bits in the output; legal range 0..OUT_W-2.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- valid_i  input  1  input word valid.
- ready_o  output  1  block can accept an input this cycle.
- data_i  input  12  float12 operand.
- relu_en_i  input  1  per-word flag: a negative result is forced to 0; travels with data_i.
- valid_o  output  1  output word valid.
- ready_i  input  1  downstream accepts the output.
- data_o  output  OUT_W  signed fixed-point result.
- sat_o  output  1  result was clamped; qualified by valid_o.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: valid_o=0, data_o=0, sat_o=0, all internal stage valids=0.
- Reset mid-operation: all in-flight words are discarded, with no output for them.
- Handshake:
  - en = ready_i | ~valid_o, and ready_o = en.
  - An input is accepted when valid_i & ready_o.
  - All three stages advance only when en=1, so a stalled output holds data_o and sat_o stable.
  - Bubbles propagate as stage-valid=0.
- Latency: an accepted word appears on valid_o exactly 3 enabled cycles later. Throughput is 1 word/cycle when ready_i=1.
- Stage 1 (unpack):
  - Register s, e, m and relu_en.
  - zero = (e==0). Mantissa is ignored when e==0, so denormals flush to 0.
  - Compute the signed shift k = e - 21 + FRAC_W.
- Stage 2 (align):
  - Significand S = {1,m}, 7 bits; value = S*2^k output LSBs.
  - k>=0: mag = S<<k, computed at width OUT_W+8 so no bits are lost; round bit r=0.
  - k<0: mag = S>>(-k), r = S[-k-1]. If -k>7: mag=0 and r=0 for -k>=9; for -k=8, r=S[7]=0.
  - zero forces mag=0, r=0.
- Stage 3 (round/saturate/sign):
  - Round half away from zero: mag' = mag + r.
  - Positive: if mag' > 2^(OUT_W-1)-1 then data_o = 2^(OUT_W-1)-1 and sat_o=1.
  - Negative: if mag' > 2^(OUT_W-1) then data_o = -2^(OUT_W-1) and sat_o=1. If mag' == 2^(OUT_W-1), the result is exact, data_o = -2^(OUT_W-1) and sat_o=0.
  - Otherwise data_o = s ? -mag' : mag' and sat_o=0.
  - Relu: s=1 & relu_en gives data_o=0 and sat_o=0. Relu has priority over saturation.
  - Negative zero (s=1, mag'=0) gives data_o=0.
- No inf/NaN encodings: e=31 is an ordinary exponent.
- Simultaneous events: an output handshake and an input accept in the same cycle both complete, with no bubble inserted.

Test Plan (OUT_W=16, FRAC_W=8):
1. Basic conversions, ready_i=1: data_i=0x3C0 (1.0) -> data_o=0x0100, sat_o=0, 3 cycles later. 0xC10 (-2.5) -> 0xFD80.
2. Zero and flush:
   - 0x000 -> 0x0000.
   - 0x03F (e=0, m≠0) -> 0x0000.
   - 0x800 -> 0x0000.
   - 0x040 (e=1) -> 0x0000 (underflow to 0).
3. Rounding:
   - 0x180 (2^-9, half LSB) -> 0x0001.
   - 0x980 -> 0xFFFF.
   - 0x140 (2^-10) -> 0x0000.
4. Saturation:
   - 0x7C0 -> 0x7FFF, sat_o=1.
   - 0xFC0 -> 0x8000, sat_o=1.
   - 0xD80 (-128.0) -> 0x8000, sat_o=0.
   - 0x580 (+128.0) -> 0x7FFF, sat_o=1.
5. Relu: 0xC10 with relu_en_i=1 -> 0x0000, sat_o=0. 0xFC0 with relu_en_i=1 -> 0x0000, sat_o=0. 0x3C0 with relu_en_i=1 -> 0x0100.
6. Backpressure and reset:
   - Stream 8 back-to-back words while ready_i toggles randomly: outputs appear in order, with no loss or duplication, and data_o stays stable while valid_o&~ready_i.
   - ready_o=0 exactly when valid_o&~ready_i.
   - Assert rst_i for 1 cycle mid-stream: valid_o=0 the next cycle, and no pre-reset word emerges afterwards.
